// File: rtl/add64_seq_ctrl.sv
// Sequences a 2W-bit add through a single W-bit adder: low pass, high pass, optional +1 pass.
// Operands are captured on accept; the result is held until the consumer takes it.
module add64_seq_ctrl #(
    parameter int unsigned W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] in_a,
    input  logic [2*W-1:0] in_b,
    output logic [W-1:0]   add_a,
    output logic [W-1:0]   add_b,
    input  logic [W-1:0]   add_s,
    input  logic           add_c,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_sum,
    output logic           out_cout,
    output logic           out_ovf
);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StLo   = 3'd1,
        StHi   = 3'd2,
        StInc  = 3'd3,
        StDone = 3'd4
    } state_e;

    state_e         state_q;
    logic [2*W-1:0] a_q;
    logic [2*W-1:0] b_q;
    logic [W-1:0]   t_q;
    logic           c_lo_q;
    logic           c_hi_q;
    logic           ovf_next;

    // Whichever pass writes the upper word also fixes the final sign bit.
    assign ovf_next = (a_q[2*W-1] == b_q[2*W-1]) && (add_s[W-1] != a_q[2*W-1]);

    // Adder operands come only from state and captured registers.
    always_comb begin
        add_a = '0;
        add_b = '0;
        case (state_q)
            StLo: begin
                add_a = a_q[W-1:0];
                add_b = b_q[W-1:0];
            end
            StHi: begin
                add_a = a_q[2*W-1:W];
                add_b = b_q[2*W-1:W];
            end
            StInc: begin
                add_a = t_q;
                add_b = W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            t_q       <= '0;
            c_lo_q    <= 1'b0;
            c_hi_q    <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid && in_ready) begin
                        a_q      <= in_a;
                        b_q      <= in_b;
                        in_ready <= 1'b0;
                        state_q  <= StLo;
                    end
                end
                StLo: begin
                    out_sum[W-1:0] <= add_s;
                    c_lo_q         <= add_c;
                    state_q        <= StHi;
                end
                StHi: begin
                    t_q    <= add_s;
                    c_hi_q <= add_c;
                    if (!c_lo_q) begin
                        out_sum[2*W-1:W] <= add_s;
                        out_cout         <= add_c;
                        out_ovf          <= ovf_next;
                        out_valid        <= 1'b1;
                        state_q          <= StDone;
                    end else begin
                        state_q <= StInc;
                    end
                end
                StInc: begin
                    // t + 1 can only carry when t is all ones, which rules out c_hi.
                    out_sum[2*W-1:W] <= add_s;
                    out_cout         <= c_hi_q | add_c;
                    out_ovf          <= ovf_next;
                    out_valid        <= 1'b1;
                    state_q          <= StDone;
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add64_seq_ctrl.sv
// Bench for add64_seq_ctrl: directed literal cases plus randomized traffic against a
// transaction-level model (expected sum, latency countdown, handshake bookkeeping).
module tb_add64_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic [31:0] add_s;
    logic        add_c;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_sum;
    logic        out_cout;
    logic        out_ovf;

    int checks   = 0;
    int failures = 0;

    add64_seq_ctrl #(.W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_s     (add_s),
        .add_c     (add_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    // Behavioural stand-in for adder_32bit (carry-in tied 0).
    assign {add_c, add_s} = {1'b0, add_a} + {1'b0, add_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lat_of(input logic [63:0] a, input logic [63:0] b);
        logic [32:0] lo;
        lo = {1'b0, a[31:0]} + {1'b0, b[31:0]};
        return lo[32] ? 3 : 2;
    endfunction

    // Transaction-level model
    logic        m_busy;
    logic        m_valid;
    int          m_wait;
    int          m_ops;
    logic [63:0] m_sum;
    logic        m_cout;
    logic        m_ovf;

    initial begin
        m_busy = 0; m_valid = 0; m_wait = 0; m_ops = 0;
        m_sum = '0; m_cout = 0; m_ovf = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_busy = 0; m_valid = 0; m_wait = 0;
            end else if (m_valid) begin
                if (out_ready) begin
                    m_valid = 0;
                    m_busy  = 0;
                    m_ops++;
                end
            end else if (m_busy) begin
                m_wait--;
                if (m_wait == 0) m_valid = 1;
            end else if (in_valid) begin
                m_busy = 1;
                m_wait = lat_of(in_a, in_b);
                {m_cout, m_sum} = {1'b0, in_a} + {1'b0, in_b};
                m_ovf = (in_a[63] == in_b[63]) && (m_sum[63] != in_a[63]);
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("in_ready", 64'(in_ready), 64'(!m_busy));
                chk("out_valid", 64'(out_valid), 64'(m_valid));
                if (m_valid) begin
                    chk("out_sum", out_sum, m_sum);
                    chk("out_cout", 64'(out_cout), 64'(m_cout));
                    chk("out_ovf", 64'(out_ovf), 64'(m_ovf));
                end
                if (!m_busy || m_valid) begin
                    chk("add_a_idle", 64'(add_a), 64'd0);
                    chk("add_b_idle", 64'(add_b), 64'd0);
                end
            end
        end
    end

    task automatic do_op(input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] e_sum, input logic e_c, input logic e_o,
                         input int e_lat, input int hold);
        int lat;
        int n;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = {$urandom, $urandom};
        in_b = {$urandom, $urandom};
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'(e_lat));
        chk("lit_sum", out_sum, e_sum);
        chk("lit_cout", 64'(out_cout), 64'(e_c));
        chk("lit_ovf", 64'(out_ovf), 64'(e_o));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom % 2);
            in_a = {$urandom, $urandom};
            @(posedge clk); #1;
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_sum", out_sum, e_sum);
            chk("hold_flags", {62'd0, out_cout, out_ovf}, {62'd0, e_c, e_o});
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_hs_valid", 64'(out_valid), 64'd0);
        chk("post_hs_ready", 64'(in_ready), 64'd1);
    endtask

    function automatic logic [63:0] pick();
        case ($urandom % 5)
            0: return {$urandom, 32'hFFFF_FFFF};
            1: return ($urandom % 2) ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h8000_0000_0000_0000;
            2: return 64'($urandom % 16);
            3: return 64'hFFFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        out_ready = 1'b0;
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_sum", out_sum, 64'd0);
        chk("rst_flags", {62'd0, out_cout, out_ovf}, 64'd0);
        chk("rst_add_a", 64'(add_a), 64'd0);
        #10 rst = 1'b0;
        @(posedge clk); #1;

        do_op(64'h1, 64'h2, 64'h3, 1'b0, 1'b0, 2, 0);
        do_op(64'h0000_0000_FFFF_FFFF, 64'h1, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 3, 0);
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1'b1, 1'b0, 3, 1);
        do_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0, 1'b1, 1'b1, 2, 0);
        do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
              64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 3, 5);

        // Reset while the high pass of an INC-path operation is in flight.
        in_a = 64'h0000_0000_FFFF_FFFF;
        in_b = 64'h1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_ready", 64'(in_ready), 64'd1);
        chk("midrst_sum", out_sum, 64'd0);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        do_op(64'd5, 64'd7, 64'd12, 1'b0, 1'b0, 2, 0);

        for (int c = 0; c < 4000; c++) begin
            in_valid = 1'($urandom % 2);
            in_a = pick();
            in_b = pick();
            out_ready = (($urandom % 4) != 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("random_ops_seen", 64'(m_ops > 200), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/add64_seq_ctrl.md
Name: add64_seq_ctrl

Overview:
- Sequencing stage directly upstream of the 32-bit carry-lookahead adder (adder_32bit: A, B in; S, C32 out; carry-in tied 0).
- Accepts 64-bit operand pairs over a valid/ready handshake and drives them through the single 32-bit adder in multiple passes: low word, high word, then an optional +1 pass.
- Returns a registered 64-bit sum, carry-out and signed-overflow flag over a valid/ready handshake.
- Lets the team do 64-bit adds without a second adder instance.

Parameters:
- W, 32, adder word width; operands and sum are 2*W bits.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset; asynchronous, active-high
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept an operand pair
- in_a  input  2W  operand A
- in_b  input  2W  operand B
- add_a  output  W  to adder A
- add_b  output  W  to adder B
- add_s  input  W  from adder S
- add_c  input  1  from adder C32
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_sum  output  2W  registered A+B modulo 2^(2W)
- out_cout  output  1  unsigned carry out of bit 2W-1
- out_ovf  output  1  signed two's-complement overflow

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state IDLE; in_ready=1, out_valid=0.
  - out_sum=0, out_cout=0, out_ovf=0.
  - Internal operand, carry and partial-sum registers = 0.
- States: IDLE, LO, HI, INC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at an edge: register in_a/in_b, go to LO.
- LO:
  - add_a=a[W-1:0], add_b=b[W-1:0].
  - At edge: out_sum[W-1:0]<=add_s, c_lo<=add_c; go to HI.
- HI:
  - add_a=a[2W-1:W], add_b=b[2W-1:W].
  - At edge: t<=add_s, c_hi<=add_c.
  - If c_lo=0: out_sum[2W-1:W]<=add_s, out_cout<=add_c; go to DONE.
  - Else go to INC.
- INC:
  - add_a=t, add_b=1.
  - At edge: out_sum[2W-1:W]<=add_s, out_cout<=c_hi|add_c (both never 1 simultaneously); go to DONE.
- DONE:
  - out_valid=1.
  - On out_ready at an edge: go to IDLE.
  - Outputs held stable while out_ready=0.
- out_ovf:
  - Registered on entry to DONE.
  - (a[2W-1]==b[2W-1]) && (final sum[2W-1]!=a[2W-1]).
- Adder drive: add_a=add_b=0 in IDLE and DONE. add_a/add_b are combinational from state and registers only, never from in_a/in_b directly.
- Latency (accept edge to out_valid):
  - 2 edges when the low pass produces no carry.
  - 3 edges when the INC pass is taken.
- Throughput: one operation at a time.
  - in_ready=1 only in IDLE; no skid buffer.
  - A new operation is accepted no earlier than the edge after the result handshake.
- Operand sampling: in_a/in_b changes after acceptance have no effect on the operation in flight.
- out_sum/out_cout/out_ovf: valid only while out_valid=1. Holding the previous result between operations is permitted but not relied on.
- Reset mid-operation (any state): immediate return to reset values, in-flight operation discarded, no out_valid pulse.
- Adder timing: add_s/add_c are treated as combinational responses within the same cycle. The full adder_32bit path from add_a/add_b back to the capture registers is a single-cycle path.
- Illegal state encodings recover to IDLE.

Test Plan:
- Basic add: a=0x0000_0000_0000_0001, b=0x0000_0000_0000_0002 -> out_sum=0x3, cout=0, ovf=0; out_valid 2 edges after accept.
- Low-word carry: a=0x0000_0000_FFFF_FFFF, b=0x1 -> out_sum=0x0000_0001_0000_0000, cout=0; INC state visited; out_valid 3 edges after accept.
- Carry ripples through INC: a=0xFFFF_FFFF_FFFF_FFFF, b=0x1 -> out_sum=0, cout=1 (from INC pass), ovf=0.
- Signed overflow, two cases:
  - a=b=0x8000_0000_0000_0000 -> sum=0, cout=1, ovf=1.
  - a=b=0x7FFF_FFFF_FFFF_FFFF -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_sum/cout/ovf stable, in_ready=0, in_valid pulses ignored; result handshake on out_ready=1, next op accepted the following edge.
- Reset mid-op: assert rst asynchronously during HI or INC -> out_valid=0, in_ready=1 immediately, out_sum=0; the next op (5+7) yields 12 normally.
